// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter: an 8-entry byte FIFO drained LSB-first
// at a programmable bit period, with a pollable status/overflow register.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hFF20_0000,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] oReadData,
  output logic        oSelected,
  output logic        oTX,
  output logic        oIRQ
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic [29:0]   word_off;
  logic          sel_tx, sel_status, sel_div, wr_en;
  logic          empty, full, busy, pop;
  logic          push_req, push_acc, ovf_set, ovf_clr;
  logic [15:0]   div_m1;
  logic          bit_end;
  logic          unused_bits;

  // Offsetting by the base lets one unsigned compare cover the three-word window.
  assign word_off   = DwAddress[31:2] - BASE_ADDR[31:2];
  assign oSelected  = (word_off < 30'd3);
  assign sel_tx     = oSelected && (word_off[1:0] == 2'd0);
  assign sel_status = oSelected && (word_off[1:0] == 2'd1);
  assign sel_div    = oSelected && (word_off[1:0] == 2'd2);
  assign wr_en      = DwWriteEnable && oSelected;

  assign unused_bits = &{1'b0, DwAddress[1:0], DwWriteData[31:16], DwByteEnable[3:2]};

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  // A zero divisor behaves as one; ">=" keeps a mid-bit shrink from hanging.
  assign div_m1  = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign bit_end = (baud_q >= div_m1);

  // FIFO bookkeeping and register writes
  always_comb begin
    push_req = wr_en && sel_tx && DwByteEnable[0];
    push_acc = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    ovf_clr  = wr_en && sel_status && DwByteEnable[1] && DwWriteData[8];
    wr_ptr_d = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_acc) - CW'(pop);
    ovf_d    = (ovf_q && !ovf_clr) || ovf_set;
    div_d    = div_q;
    if (wr_en && sel_div) begin
      if (DwByteEnable[0]) div_d[7:0]  = DwWriteData[7:0];
      if (DwByteEnable[1]) div_d[15:8] = DwWriteData[15:8];
    end
  end

  // TX FSM next state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = 3'd0;
          baud_d  = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (!empty) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX FSM outputs
  always_comb begin
    oTX  = 1'b1;
    busy = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      START:   oTX  = 1'b0;
      DATA:    oTX  = shift_q[0];
      default: oTX  = 1'b1;
    endcase
    oIRQ = empty && !busy;
  end

  always_comb begin
    oReadData = 32'd0;
    if (DwReadEnable && oSelected) begin
      if (sel_status)
        oReadData = {23'd0, ovf_q, count_q, 1'b0, busy, full, empty};
      else if (sel_div)
        oReadData = {16'd0, div_q};
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      div_q    <= DIV_RESET;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge iCLK) begin
    if (push_acc) mem_q[wr_ptr_q] <= DwWriteData[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: stimulus queues expected reads and frames; monitors
// decode the bus and the TX line independently and compare against the queues.
module tb_uart_tx_mmio;
  localparam logic [31:0] A_TX  = 32'hFF20_0000;
  localparam logic [31:0] A_ST  = 32'hFF20_0004;
  localparam logic [31:0] A_DIV = 32'hFF20_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        sel, tx, irq;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .iCLK(clk), .iRST(rst),
    .DwReadEnable(re), .DwWriteEnable(we), .DwByteEnable(be),
    .DwAddress(addr), .DwWriteData(wdata),
    .oReadData(rdata), .oSelected(sel), .oTX(tx), .oIRQ(irq)
  );

  typedef struct { string name; logic [31:0] val; } rd_exp_t;
  typedef struct { logic [7:0] data; bit contig; } fr_exp_t;

  rd_exp_t rd_q[$];
  fr_exp_t fr_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int cur_div = 434;
  int last_end = -100;
  int irq_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_total++;
    $display("FAIL %s: event seen/timed out, required otherwise", name);
  endtask

  // Bus read monitor
  always @(negedge clk) begin
    if (!rst && re && sel) begin
      if (rd_q.size() == 0) fail_evt("unexpected read");
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check(e.name, rdata, e.val);
      end
    end
  end

  // TX line monitor: one frame = 10 bits of fdiv samples each
  bit          in_frame = 1'b0;
  int          idx = 0;
  int          fdiv = 1;
  logic        samp [0:63];
  logic [9:0]  rx;
  logic        steady;
  fr_exp_t     fe;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        idx = 0;
        fdiv = cur_div;
        if (fr_q.size() == 0) fail_evt("unexpected frame start");
        else if (fr_q[0].contig) check("frame gap", cyc, last_end + 1);
      end
      if (in_frame) begin
        samp[idx] = tx;
        idx++;
        if (idx == 10 * fdiv) begin
          in_frame = 1'b0;
          last_end = cyc;
          rx = '0;
          steady = 1'b1;
          for (int b = 0; b < 10; b++) begin
            rx[b] = samp[b * fdiv];
            for (int k = 1; k < fdiv; k++)
              if (samp[b * fdiv + k] !== samp[b * fdiv]) steady = 1'b0;
          end
          if (fr_q.size() == 0) fail_evt("unexpected frame");
          else begin
            fe = fr_q.pop_front();
            check("frame bits", 32'(rx), 32'({1'b1, fe.data, 1'b0}));
            check("frame steady", 32'(steady), 32'd1);
          end
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [3:0] lanes, input logic [31:0] d);
    addr = a; be = lanes; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; be = 4'd0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.name = name;
    e.val = exp;
    rd_q.push_back(e);
    addr = a; re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] d, input bit contig);
    fr_exp_t e;
    e.data = d;
    e.contig = contig;
    fr_q.push_back(e);
  endtask

  task automatic wait_irq(input int limit);
    int n = 0;
    @(negedge clk);
    while (irq !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (irq !== 1'b1) fail_evt("irq timeout");
    else begin
      irq_cyc = cyc;
      check("irq after stop", irq_cyc, last_end + 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset tx", 32'(tx), 32'd1);
    check("reset irq", 32'(irq), 32'd1);
    rd("reset STATUS", A_ST, 32'h001);
    rd("reset DIVISOR", A_DIV, 32'd434);

    // Single frame at divisor 4
    wr(A_DIV, 4'b0011, 32'd4);
    cur_div = 4;
    push_frame(8'hA5, 1'b0);
    wr(A_TX, 4'b0001, 32'hA5);
    @(negedge clk);
    check("tx before pop", 32'(tx), 32'd1);
    @(negedge clk);
    check("tx start edge", 32'(tx), 32'd0);
    wait_irq(200);
    rd("STATUS after frame", A_ST, 32'h001);

    // Fill, overflow, clear at divisor 2
    wr(A_DIV, 4'b0011, 32'd2);
    cur_div = 2;
    for (int i = 0; i < 9; i++) begin
      push_frame(8'(17 + i), i > 0);
      wr(A_TX, 4'b0001, 32'(17 + i));
    end
    rd("STATUS full", A_ST, 32'h086);
    wr(A_TX, 4'b0001, 32'h99);
    rd("STATUS overflow", A_ST, 32'h186);
    wr(A_ST, 4'b0010, 32'h100);
    rd("STATUS ovf cleared", A_ST, 32'h086);
    wait_irq(600);
    rd("STATUS drained", A_ST, 32'h001);

    // Back-to-back at divisor 1
    wr(A_DIV, 4'b0011, 32'd1);
    cur_div = 1;
    push_frame(8'h00, 1'b0);
    push_frame(8'hFF, 1'b1);
    wr(A_TX, 4'b0001, 32'h00);
    wr(A_TX, 4'b0001, 32'hFF);
    wait_irq(100);

    // Divisor 0 acts as 1
    wr(A_DIV, 4'b0011, 32'd0);
    cur_div = 1;
    rd("DIVISOR zero", A_DIV, 32'd0);
    push_frame(8'h3C, 1'b0);
    wr(A_TX, 4'b0001, 32'h3C);
    wait_irq(100);

    // Reset mid-frame with bytes queued
    wr(A_DIV, 4'b0011, 32'd4);
    cur_div = 4;
    push_frame(8'h81, 1'b0);
    wr(A_TX, 4'b0001, 32'h81);
    wr(A_TX, 4'b0001, 32'h42);
    wr(A_TX, 4'b0001, 32'h24);
    repeat (8) @(posedge clk);
    #1;
    check("tx low in data", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("tx async reset", 32'(tx), 32'd1);
    check("irq in reset", 32'(irq), 32'd1);
    fr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd("DIVISOR after reset", A_DIV, 32'd434);
    rd("STATUS after reset", A_ST, 32'h001);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("tx quiet after reset", lows, 0);

    check("pending reads", rd_q.size(), 0);
    check("pending frames", fr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped serial transmitter that answers as a responder on the processor's data bus (Dw* read/write enables, byte enables, address, write data) and returns read data for the top-level read-data mux. Bytes stored by software into an 8-entry FIFO are serialised on a single TX line as 8N1 frames, LSB first, at a software-programmable bit period. A status register exposes FIFO occupancy, busy, and a sticky overflow flag so programs can poll before storing.

## Interface
- BASE_ADDR, 32'hFF20_0000 — byte address of register 0; the block decodes BASE_ADDR..BASE_ADDR+0xB.
- DIV_RESET, 16'd434 — reset value of the DIVISOR register; 50 MHz / 115200 baud.
- FIFO_DEPTH, 8 — number of FIFO entries; power of two, fixed at 8 for this revision.

Ports:
- iCLK  in  1  — single clock; all state changes on the rising edge.
- iRST  in  1  — asynchronous, active-high reset.
- DwReadEnable  in  1  — bus read strobe.
- DwWriteEnable  in  1  — bus write strobe.
- DwByteEnable  in  4  — byte lanes of the write; bit0 = DwWriteData[7:0].
- DwAddress  in  32  — byte address; bits [1:0] ignored.
- DwWriteData  in  32  — store data.
- oReadData  out  32  — read data; combinational, 0 when not selected or DwReadEnable low.
- oSelected  out  1  — combinational; high when DwAddress[31:2] falls in the decoded window.
- oTX  out  1  — serial line; idle high.
- oIRQ  out  1  — high when FIFO empty and transmitter IDLE.

## Operation
- Registers (offset from BASE_ADDR):
  - 0x0 TXDATA — write with DwByteEnable[0]=1 pushes DwWriteData[7:0]; reads return 0.
  - 0x4 STATUS — read: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bits[7:4] count 0..8, bit8 overflow, others 0. Write with DwByteEnable[1]=1 and DwWriteData[8]=1 clears overflow.
  - 0x8 DIVISOR — bits[15:0] R/W; lane 0 writes [7:0], lane 1 writes [15:8]; reads zero-extend. Value 0 is treated as 1.
- Writes take effect at the rising edge with DwWriteEnable=1 and oSelected=1. Reads have no side effects.
- FIFO: circular, 3-bit read/write pointers, 4-bit count.
  - Push when full and no pop in the same cycle: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both happen; count stays 8, no overflow.
  - Overflow clear and new overflow in the same cycle: set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: oTX=1. If count>0: pop head into shift register, bit counter cleared, go START.
  - START: oTX=0 for DIVISOR cycles, then DATA.
  - DATA: oTX=shift[0] for DIVISOR cycles per bit; shift right after each bit; after bit 7 go STOP.
  - STOP: oTX=1 for DIVISOR cycles. On the last cycle, if count>0: pop and go START directly (back-to-back frames); else go IDLE.
- Baud counter: counts 0..eff_div-1, where eff_div is the live DIVISOR (0 is read as 1). A bit ends when count >= eff_div-1. A DIVISOR write mid-bit therefore applies from the current bit onward, without a hang.

## Timing
- Reset values: oTX=1; FIFO empty (count 0, pointers 0); overflow 0; DIVISOR=DIV_RESET; FSM IDLE; oIRQ=1. oReadData is 0 whenever no read is presented.
- iRST asserted mid-frame: oTX is forced high immediately (asynchronously), FIFO is flushed, DIVISOR returns to DIV_RESET.
- Latency: a TXDATA write at edge N into an idle, empty block gives count=1 after N. The pop occurs at N+1, and oTX falls after edge N+1.
- Frame length: exactly 10×eff_div cycles.
- Back-to-back frames: no idle gap between STOP and the next START.
- STATUS reflects pushes and pops of the previous edge; no same-cycle forwarding.

## Test plan
- Reset, then read STATUS and DIVISOR → STATUS=0x001, DIVISOR=434, oTX=1, oIRQ=1.
- DIVISOR=4; write TXDATA=0xA5 → oTX falls one cycle after the write edge. Then line sequence 0,1,0,1,0,0,1,0,1,1 with each bit held exactly 4 cycles (LSB first). STATUS=0x001 after the frame.
- DIVISOR=2; write 9 bytes in consecutive cycles → first byte popped at edge 2, so bytes 2–9 fill the FIFO (count 8, full). No overflow is raised. A 10th immediate write sets STATUS bit8. Writing 0x100 to STATUS clears it.
- DIVISOR=1; write 0x00, 0xFF back-to-back → 20 contiguous line cycles with no idle between frames; oIRQ rises after the second STOP.
- DIVISOR=0 written → behaves as 1; DIVISOR reads back 0; frame = 10 cycles.
- Assert iRST during DATA of a frame with 3 bytes queued → oTX=1 the same cycle, STATUS=0x001 after release, no further frames emitted.
